// File: rtl/fm_iq_capture_ctrl.sv
// FM front-end controller: host command decode, round-robin ADC mux sequencing,
// channel-tagged sample capture into a DEPTH-word buffer, and registered readback.
module fm_iq_capture_ctrl #(
  parameter int                  ADDR_W    = 8,
  parameter int                  ADC_W     = 12,
  parameter int                  NUM_CH    = 2,
  parameter logic [3*NUM_CH-1:0] CH_LIST   = 6'o64,
  parameter int                  DEPTH     = 16,
  parameter int                  CTRL_ADDR = 4,
  parameter int                  STAT_ADDR = 8,
  parameter int                  BUF_BASE  = 32
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wea,
  input  logic [ADDR_W-1:0] rdaddr,
  output logic [31:0]       rdata,
  input  logic              adc_eoc,
  input  logic [ADC_W-1:0]  adc_data,
  output logic [2:0]        adc_channel,
  output logic              adc_pd,
  output logic [3:0]        fm_hw_state,
  output logic              dump_done_irq
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH) + 1;

  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(CTRL_ADDR);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STAT_ADDR);
  localparam logic [ADDR_W:0]   BUF_LO = (ADDR_W+1)'(BUF_BASE);
  localparam logic [ADDR_W:0]   BUF_HI = (ADDR_W+1)'(BUF_BASE + DEPTH);
  localparam logic [PW-1:0]     LAST   = PW'(DEPTH - 1);

  // The encoding is the externally visible fm_hw_state value.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0000,
    ST_RCEV      = 4'b0010,
    ST_RSSI      = 4'b0100,
    ST_RSSI_DONE = 4'b1000
  } state_t;

  state_t          state, state_nxt;
  logic            armed, armed_nxt;
  logic [PW-1:0]   wptr, wptr_nxt;
  logic [SW-1:0]   slot, slot_nxt;
  logic [2:0]      ch_nxt;
  logic            irq_nxt;
  logic [31:0]     rdata_nxt;
  logic [31:0]     mem [DEPTH];

  // Write bus has no handshake: a command is taken in any single cycle where
  // wraddr==CTRL_ADDR and all four byte enables are set; partial writes are dropped.
  logic ctrl_wr, f1, f2, f3, f4;
  logic cmd_rcev, cmd_idle, cmd_rssi, cmd_done, cmd_arm;

  assign ctrl_wr  = (wraddr == CTRL_A) && (wea == 4'hf);
  assign f1       = (wdata[7:4] == 4'h1);
  assign f2       = (wdata[7:4] == 4'h2);
  assign f3       = (wdata[15:8] == 8'h01);
  assign f4       = (wdata[15:8] == 8'h02);
  assign cmd_rcev = ctrl_wr && f1;
  assign cmd_idle = ctrl_wr && !f1 && f2;
  assign cmd_rssi = ctrl_wr && !f1 && !f2 && f3;
  assign cmd_done = ctrl_wr && !f1 && !f2 && !f3 && f4;
  assign cmd_arm  = ctrl_wr && wdata[16];

  // An arm in the same cycle as an eoc restarts the buffer and drops that sample.
  logic        capture;
  logic [31:0] sample_word;

  assign capture     = adc_eoc && armed && (state == ST_RCEV) && !cmd_arm;
  assign sample_word = {12'b0, 4'(slot), 16'(adc_data)};

  assign fm_hw_state = state;
  assign adc_pd      = (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    if (cmd_rcev)      state_nxt = ST_RCEV;
    else if (cmd_idle) state_nxt = ST_IDLE;
    else if (cmd_rssi) state_nxt = ST_RSSI;
    else if (cmd_done) state_nxt = ST_RSSI_DONE;
  end

  always_comb begin
    armed_nxt = armed;
    wptr_nxt  = wptr;
    irq_nxt   = 1'b0;
    if (capture) begin
      wptr_nxt = wptr + PW'(1);
      if (wptr == LAST) begin
        armed_nxt = 1'b0;
        irq_nxt   = 1'b1;
      end
    end
    if (cmd_idle) begin
      armed_nxt = 1'b0;
      wptr_nxt  = '0;
    end
    if (cmd_arm) begin
      armed_nxt = 1'b1;
      wptr_nxt  = '0;
    end
  end

  always_comb begin
    slot_nxt = slot;
    if (adc_eoc) slot_nxt = (slot == SW'(NUM_CH - 1)) ? '0 : slot + SW'(1);
    ch_nxt = CH_LIST[2:0];
    for (int k = 0; k < NUM_CH; k++) begin
      if (slot_nxt == SW'(k)) ch_nxt = CH_LIST[3*k +: 3];
    end
  end

  logic [ADDR_W:0] rd_ext, rd_off;
  logic            in_buf;

  assign rd_ext = {1'b0, rdaddr};
  assign rd_off = rd_ext - BUF_LO;
  assign in_buf = (rd_ext >= BUF_LO) && (rd_ext < BUF_HI);

  always_comb begin
    rdata_nxt = '0;
    if (rdaddr == STAT_A)      rdata_nxt = {state, 3'b0, armed, 8'b0, 16'(wptr)};
    else if (rdaddr == CTRL_A) rdata_nxt = {28'b0, state};
    else if (in_buf)           rdata_nxt = mem[rd_off[AW-1:0]];
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state         <= ST_IDLE;
      armed         <= 1'b0;
      wptr          <= '0;
      slot          <= '0;
      adc_channel   <= CH_LIST[2:0];
      dump_done_irq <= 1'b0;
      rdata         <= '0;
    end else begin
      state         <= state_nxt;
      armed         <= armed_nxt;
      wptr          <= wptr_nxt;
      slot          <= slot_nxt;
      adc_channel   <= ch_nxt;
      dump_done_irq <= irq_nxt;
      rdata         <= rdata_nxt;
    end
  end

  // Buffer contents survive reset; a same-cycle read sees the previous word.
  always_ff @(posedge clk) begin
    if (capture) mem[wptr[AW-1:0]] <= sample_word;
  end

  logic unused_bits;
  assign unused_bits = ^{wdata[31:17], wdata[3:0], rd_off[ADDR_W:AW]};

endmodule
